axi_wsel_tracker: RTL

// - Upstream companion of the W-channel slave mux: records the slave index of every accepted AW

---
 rtl/axi_ic_pkg.sv | 29 ++
 rtl/axi_sel_fifo.sv | 71 +++++++
 rtl/axi_wsel_tracker.sv | 127 ++++++++++++
 3 files changed

// File: rtl/axi_ic_pkg.sv
// ============================================================================
// Module      : axi_ic_pkg
// Description : Shared interconnect constants and the W-select queue entry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_ic_pkg;

    localparam logic [3:0]  SEL_NONE   = 4'hF;
    localparam int unsigned NUM_SLV    = 4;

    localparam logic [3:0]  SLV0       = 4'd0;
    localparam logic [3:0]  SLV1       = 4'd1;
    localparam logic [3:0]  SLV2       = 4'd2;
    localparam logic [3:0]  SLV3       = 4'd3;

    // AXI4 AWLEN width carried in each queued entry.
    localparam int unsigned WSEL_LEN_W = 8;

    typedef struct packed {
        logic [3:0]            sel;
        logic                  unmapped;
        logic [WSEL_LEN_W-1:0] len;
    } wsel_entry_t;

endpackage

`default_nettype wire

// File: rtl/axi_sel_fifo.sv
// ============================================================================
// Module      : axi_sel_fifo
// Description : Generic synchronous FIFO with count-based full/empty flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_sel_fifo #(
    parameter int unsigned DEPTH   = 4,
    parameter type         ENTRY_T = logic [7:0]
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  ENTRY_T                       push_data_i,
    input  logic                         pop_i,
    output ENTRY_T                       head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int unsigned           c_PTR_W = $clog2(DEPTH);
    localparam int unsigned           c_CNT_W = $clog2(DEPTH+1);
    localparam logic [c_CNT_W-1:0]    c_FULL  = c_CNT_W'(DEPTH);

    ENTRY_T               r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic                 w_push;
    logic                 w_pop;

    // Flags come only from the registered count; pointers wrap naturally (DEPTH is a power of 2).
    assign full_o  = (r_count == c_FULL);
    assign empty_o = (r_count == '0);
    assign count_o = r_count;
    assign head_o  = r_mem[r_rd_ptr];

    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/axi_wsel_tracker.sv
// ============================================================================
// Module      : axi_wsel_tracker
// Description : Queues AW slave selects in order and steers W beats to the W mux.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_wsel_tracker
    import axi_ic_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned LEN_W  = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         m_awvalid_i,
    input  logic [ADDR_W-1:0]            m_awaddr_i,
    input  logic [LEN_W-1:0]             m_awlen_i,
    output logic                         m_awready_o,
    output logic                         s_awvalid_o,
    input  logic                         s_awready_i,
    input  logic                         m_wvalid_i,
    input  logic                         m_wlast_i,
    output logic                         m_wready_o,
    output logic                         wvalid_o,
    input  logic                         wready_i,
    output logic [3:0]                   s_wsel_o,
    output logic [$clog2(DEPTH+1)-1:0]   outstanding_o,
    output logic                         len_err_o
);

    wsel_entry_t          w_push_entry;
    wsel_entry_t          w_head;
    logic [3:0]           w_addr_sel;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_aw_fire;
    logic                 w_w_fire;
    logic                 w_pop;
    logic                 w_at_len;
    logic                 w_len_err;
    logic                 w_unused_addr;

    logic [LEN_W-1:0]     r_beat_cnt;
    logic                 r_len_flagged;
    logic                 r_len_err;

    assign m_awready_o   = s_awready_i & ~w_full;
    assign s_awvalid_o   = m_awvalid_i & ~w_full;
    assign w_aw_fire     = s_awvalid_o & s_awready_i;
    assign w_unused_addr = ^m_awaddr_i[ADDR_W-5:0];

    always_comb begin
        w_addr_sel         = m_awaddr_i[ADDR_W-1 -: 4];
        w_push_entry.len   = m_awlen_i;
        w_push_entry.sel   = SEL_NONE;
        w_push_entry.unmapped = 1'b1;
        if (w_addr_sel < 4'(NUM_SLV)) begin
            w_push_entry.sel      = w_addr_sel;
            w_push_entry.unmapped = 1'b0;
        end
    end

    axi_sel_fifo #(
        .DEPTH   (DEPTH),
        .ENTRY_T (wsel_entry_t)
    ) u_sel_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (w_aw_fire),
        .push_data_i (w_push_entry),
        .pop_i       (w_pop),
        .head_o      (w_head),
        .count_o     (outstanding_o),
        .full_o      (w_full),
        .empty_o     (w_empty)
    );

    // W is only released by a queued head, so data can never overtake its AW.
    always_comb begin
        s_wsel_o   = SEL_NONE;
        wvalid_o   = 1'b0;
        m_wready_o = 1'b0;
        if (!w_empty) begin
            s_wsel_o = w_head.sel;
            if (w_head.unmapped) begin
                m_wready_o = 1'b1;
            end else begin
                wvalid_o   = m_wvalid_i;
                m_wready_o = wready_i;
            end
        end
    end

    assign w_w_fire  = m_wvalid_i & m_wready_o;
    assign w_pop     = w_w_fire & m_wlast_i;
    assign w_at_len  = (r_beat_cnt == w_head.len);
    // A missing WLAST is reported once; the counter then parks at len until WLAST arrives.
    assign w_len_err = w_w_fire & ((m_wlast_i & ~w_at_len) |
                                   (~m_wlast_i & w_at_len & ~r_len_flagged));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_beat_cnt    <= '0;
            r_len_flagged <= 1'b0;
            r_len_err     <= 1'b0;
        end else begin
            r_len_err <= w_len_err;
            if (w_pop) begin
                r_beat_cnt    <= '0;
                r_len_flagged <= 1'b0;
            end else if (w_w_fire) begin
                if (!w_at_len) begin
                    r_beat_cnt <= r_beat_cnt + 1'b1;
                end else begin
                    r_len_flagged <= 1'b1;
                end
            end
        end
    end

    assign len_err_o = r_len_err;

endmodule

`default_nettype wire
